// File: rtl/mbus_resp.sv
// mbus_resp: CPU bus responder decoding ROM, work RAM, VRAM and IO ports with a registered read path.
// Define MBUS_WDOG_EN to build the vblank watchdog; otherwise wdog_rst is tied low.
module mbus_resp #(
  parameter int RAM_AW = 11,
  parameter int WDOG_FRAMES = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_io,
  input  logic        cpu_m1,
  output logic [7:0]  cpu_din,
  input  logic        vb,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [10:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  input  logic [7:0]  p1,
  input  logic [7:0]  p2,
  input  logic [7:0]  dsw,
  output logic        flip,
  output logic        nmi_en,
  output logic [7:0]  snd_cmd,
  output logic        snd_stb,
  output logic        wdog_rst
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;
  state_t state;
  logic rd_q, wr_q, io, rom_sel, ram_sel, vram_sel, rd_edge, wr_edge, io_wr;
  logic [7:0] port, rd_data, ram_q;
  logic [7:0] ram [2**RAM_AW];
  assign rom_addr = cpu_ab[14:0];
  assign vram_addr = cpu_ab[10:0];
  assign port = cpu_ab[7:0];
  assign io = cpu_io && !cpu_m1;
  assign rom_sel = !cpu_io && !cpu_ab[15];
  assign ram_sel = !cpu_io && cpu_ab[15:11] == 5'b10000;
  assign vram_sel = !cpu_io && cpu_ab[15:11] == 5'b10010;
  assign rd_edge = cpu_rd && !rd_q;
  // a write strobe that rises while a read is in progress is swallowed, not deferred
  assign wr_edge = reset_n && cpu_wr && !wr_q && !cpu_rd;
  assign io_wr = wr_edge && io;
  always_comb
    rd_data = rom_sel ? rom_data :
              ram_sel ? ram_q :
              vram_sel ? vram_rdata :
              !io ? 8'hFF :
              port == 8'h00 ? p1 :
              port == 8'h01 ? p2 :
              port == 8'h02 ? dsw : 8'hFF;
  always_ff @(posedge clk_sys) begin
    if (wr_edge && ram_sel) ram[cpu_ab[RAM_AW-1:0]] <= cpu_dout;
    ram_q <= ram[cpu_ab[RAM_AW-1:0]];
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cpu_din <= 8'hFF;
      flip <= 1'b0;
      nmi_en <= 1'b0;
      snd_cmd <= 8'h00;
      snd_stb <= 1'b0;
      vram_we <= 1'b0;
      vram_wdata <= 8'h00;
    end else begin
      rd_q <= cpu_rd;
      wr_q <= cpu_wr;
      state <= state == IDLE ? (rd_edge ? ADDR : IDLE) :
               state == ADDR ? DATA :
               state == DATA ? HOLD : (cpu_rd ? HOLD : IDLE);
      if (state == ADDR) cpu_din <= rd_data;
      vram_we <= wr_edge && vram_sel;
      if (wr_edge && vram_sel) vram_wdata <= cpu_dout;
      if (io_wr && port == 8'h00) {nmi_en, flip} <= cpu_dout[1:0];
      if (io_wr && port == 8'h01) snd_cmd <= cpu_dout;
      snd_stb <= io_wr && port == 8'h01;
    end
`ifdef MBUS_WDOG_EN
  localparam int CW = $clog2(WDOG_FRAMES + 1);
  logic vb_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      vb_q <= 1'b0;
      cnt <= '0;
      wdog_rst <= 1'b0;
    end else begin
      vb_q <= vb;
      wdog_rst <= 1'b0;
      if (io_wr && port == 8'h03) cnt <= '0;
      else if (vb && !vb_q) begin
        cnt <= cnt == CW'(WDOG_FRAMES - 1) ? '0 : cnt + CW'(1);
        wdog_rst <= cnt == CW'(WDOG_FRAMES - 1);
      end
    end
`else
  logic unused_ok;
  assign unused_ok = vb;
  assign wdog_rst = 1'b0;
`endif
endmodule

// File: tb/tb_mbus_resp.sv
// tb_mbus_resp: randomized scoreboard bench for mbus_resp against a range-based reference model.
// Define MBUS_WDOG_EN for both bench and RTL to exercise the watchdog.
`timescale 1ns/1ps
module tb_mbus_resp;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset_n = 0;
  logic [15:0] cpu_ab = 0;
  logic [7:0] cpu_dout = 0, rom_data = 0, vram_rdata = 0, p1 = 0, p2 = 0, dsw = 0;
  logic cpu_rd = 0, cpu_wr = 0, cpu_io = 0, cpu_m1 = 0, vb = 0;
  logic [7:0] cpu_din, vram_wdata, snd_cmd;
  logic [14:0] rom_addr;
  logic [10:0] vram_addr;
  logic vram_we, flip, nmi_en, snd_stb, wdog_rst;
  int total = 0, bad = 0;
  logic [7:0] ext_vram [2048] = '{default: 8'h00};
  logic [7:0] ref_vram [2048] = '{default: 8'h00};
  logic [7:0] ref_ram [2048] = '{default: 8'h00};
  logic ref_flip = 0, ref_nmi = 0;
  logic [7:0] ref_snd = 0;
  int ref_wcnt = 0, wd_exp = 0;
  logic [7:0] rd_exp[$], snd_exp[$];
  logic [18:0] vw_exp[$];

  mbus_resp dut (
    .clk_sys(clk), .reset_n(reset_n), .cpu_ab(cpu_ab), .cpu_dout(cpu_dout),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_io(cpu_io), .cpu_m1(cpu_m1),
    .cpu_din(cpu_din), .vb(vb), .rom_addr(rom_addr), .rom_data(rom_data),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata), .p1(p1), .p2(p2), .dsw(dsw), .flip(flip),
    .nmi_en(nmi_en), .snd_cmd(snd_cmd), .snd_stb(snd_stb), .wdog_rst(wdog_rst)
  );

  function automatic logic [7:0] rom_f(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h96;
  endfunction

  // external ROM and VRAM devices, both with one cycle of read latency
  always @(posedge clk) begin
    rom_data <= rom_f(rom_addr);
    vram_rdata <= ext_vram[vram_addr];
    if (vram_we) ext_vram[vram_addr] <= vram_wdata;
  end

  function automatic logic [7:0] ref_rd(input logic io, input logic m1, input logic [15:0] ab);
    if (io) return m1 ? 8'hFF : ab[7:0] == 0 ? p1 : ab[7:0] == 1 ? p2 : ab[7:0] == 2 ? dsw : 8'hFF;
    if (ab < 16'h8000) return rom_f(ab[14:0]);
    if (ab >= 16'h8000 && ab < 16'h8800) return ref_ram[ab - 16'h8000];
    if (ab >= 16'h9000 && ab < 16'h9800) return ref_vram[ab - 16'h9000];
    return 8'hFF;
  endfunction

  function automatic void ref_wr(input logic io, input logic [15:0] ab, input logic [7:0] d);
    if (io) begin
      if (ab[7:0] == 0) begin ref_flip = d[0]; ref_nmi = d[1]; end
      if (ab[7:0] == 1) begin ref_snd = d; snd_exp.push_back(d); end
      if (ab[7:0] == 3) ref_wcnt = 0;
    end else if (ab >= 16'h8000 && ab < 16'h8800) ref_ram[ab - 16'h8000] = d;
    else if (ab >= 16'h9000 && ab < 16'h9800) begin
      ref_vram[ab - 16'h9000] = d;
      vw_exp.push_back({ab[10:0], d});
    end
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_rd(input logic io, input logic m1, input logic [15:0] ab);
    cpu_ab = ab; cpu_io = io; cpu_m1 = m1; cpu_rd = 1;
    rd_exp.push_back(ref_rd(io, m1, ab));
    cyc(4);
    cpu_rd = 0;
    cyc(2);
  endtask

  // data is flipped after the first cycle so a repeated write would be visible
  task automatic do_wr(input logic io, input logic [15:0] ab, input logic [7:0] d, input int hold);
    cpu_ab = ab; cpu_io = io; cpu_m1 = 0; cpu_dout = d; cpu_wr = 1;
    ref_wr(io, ab, d);
    cyc(1);
    cpu_dout = ~d;
    cyc(hold - 1);
    cpu_wr = 0;
    cyc(2);
    chk("flip", flip, ref_flip);
    chk("nmi_en", nmi_en, ref_nmi);
    chk("snd_cmd", snd_cmd, ref_snd);
  endtask

  task automatic vb_pulse();
`ifdef MBUS_WDOG_EN
    ref_wcnt++;
    if (ref_wcnt == 8) begin ref_wcnt = 0; wd_exp++; end
`endif
    vb = 1;
    cyc(2);
    vb = 0;
    cyc(2);
  endtask

  initial begin : monitor
    int age;
    logic rd_prev;
    logic [18:0] v;
    age = -1;
    rd_prev = 0;
    forever begin
      @(negedge clk);
      if (cpu_rd && !rd_prev) age = 0;
      else if (age >= 0) age++;
      rd_prev = cpu_rd;
      if (age == 2) begin
        age = -1;
        if (rd_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got read with empty queue");
        end else chk("cpu_din", cpu_din, rd_exp.pop_front());
      end
      if (vram_we) begin
        chk("vram_we", vram_we, vw_exp.size() != 0);
        if (vw_exp.size() != 0) begin
          v = vw_exp.pop_front();
          chk("vram_addr", vram_addr, v[18:8]);
          chk("vram_wdata", vram_wdata, v[7:0]);
        end
      end
      if (snd_stb) begin
        chk("snd_stb", snd_stb, snd_exp.size() != 0);
        if (snd_exp.size() != 0) chk("snd_stb_cmd", snd_cmd, snd_exp.pop_front());
      end
      if (wdog_rst) begin
        chk("wdog_rst", wdog_rst, wd_exp > 0);
        if (wd_exp > 0) wd_exp--;
      end
    end
  end

  initial begin
    logic [15:0] a;
    cyc(3);
    chk("rst_cpu_din", cpu_din, 8'hFF);
    chk("rst_flip", flip, 0);
    chk("rst_nmi", nmi_en, 0);
    chk("rst_snd_cmd", snd_cmd, 0);
    chk("rst_snd_stb", snd_stb, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_wdog", wdog_rst, 0);
    reset_n = 1;
    cyc(2);
    for (int i = 0; i < 16; i++) do_wr(0, 16'h8000 + 16'(i), 8'($urandom), 1);
    do_wr(0, 16'h8123, 8'h5A, 17);
    do_rd(0, 0, 16'h8123);
    do_wr(0, 16'h9123, 8'hC3, 5);
    do_rd(0, 0, 16'h9123);
    dsw = 8'hA5;
    do_rd(1, 0, 16'h0002);
    do_rd(1, 1, 16'h0002);
    do_wr(1, 16'h0001, 8'h3C, 3);
    do_wr(1, 16'h0000, 8'h03, 2);
    do_rd(0, 0, 16'hC000);
    do_wr(0, 16'hC000, 8'h77, 2);
    do_rd(0, 0, 16'h0000);
    do_rd(0, 0, 16'h7FFF);
    do_rd(0, 0, 16'h87FF);
    // write strobe during an active read must be dropped
    cpu_ab = 16'h9010; cpu_io = 0; cpu_m1 = 0; cpu_rd = 1;
    rd_exp.push_back(ref_rd(0, 0, 16'h9010));
    cyc(2);
    cpu_dout = 8'hEE; cpu_wr = 1;
    cyc(2);
    cpu_wr = 0;
    cyc(1);
    cpu_rd = 0;
    cyc(2);
    do_rd(0, 0, 16'h9010);
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 7))
        0: do_rd(0, $urandom_range(0, 1) == 1, 16'($urandom_range(0, 16'h7FFF)));
        1: do_wr(0, 16'h8000 + 16'($urandom_range(0, 15)), 8'($urandom), $urandom_range(1, 4));
        2: do_rd(0, 0, 16'h8000 + 16'($urandom_range(0, 15)));
        3: do_wr(0, 16'h9000 + 16'($urandom_range(0, 15)), 8'($urandom), $urandom_range(1, 4));
        4: do_rd(0, 0, 16'h9000 + 16'($urandom_range(0, 15)));
        5: begin
          p1 = 8'($urandom); p2 = 8'($urandom); dsw = 8'($urandom);
          a = {8'($urandom), 8'($urandom_range(0, 3))};
          do_rd(1, $urandom_range(0, 3) == 0, a);
        end
        6: do_wr(1, {8'($urandom), 8'($urandom_range(0, 3))}, 8'($urandom), $urandom_range(1, 3));
        default: begin
          a = 16'hA000 + 16'($urandom_range(0, 16'h5FFF));
          if ($urandom_range(0, 1) == 1) do_rd(0, 0, a);
          else do_wr(0, a, 8'($urandom), 2);
        end
      endcase
    end
    do_wr(1, 16'h0003, 8'h00, 1);
    repeat (8) vb_pulse();
    cyc(2);
    chk("wdog_8_edges", wd_exp, 0);
    repeat (7) vb_pulse();
    do_wr(1, 16'h0003, 8'h00, 1);
    repeat (7) vb_pulse();
    cyc(2);
    chk("wdog_kicked", wd_exp, 0);
    vb_pulse();
    cyc(2);
    chk("wdog_after_kick", wd_exp, 0);
    // reset arriving while the read FSM is in DATA
    do_wr(1, 16'h0001, 8'h81, 1);
    cpu_ab = 16'h8123; cpu_io = 0; cpu_m1 = 0; cpu_rd = 1;
    rd_exp.push_back(8'hFF);
    cyc(2);
    reset_n = 0;
    cyc(1);
    chk("mid_rst_cpu_din", cpu_din, 8'hFF);
    chk("mid_rst_snd_cmd", snd_cmd, 8'h00);
    chk("mid_rst_flip", flip, 0);
    cpu_rd = 0;
    cyc(2);
    reset_n = 1;
    ref_flip = 0; ref_nmi = 0; ref_snd = 0; ref_wcnt = 0;
    cyc(2);
    do_rd(0, 0, 16'h8123);
    do_wr(1, 16'h0000, 8'h02, 1);
    cyc(5);
    chk("rd_left", rd_exp.size(), 0);
    chk("vram_left", vw_exp.size(), 0);
    chk("snd_left", snd_exp.size(), 0);
    chk("wdog_left", wd_exp, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mbus_resp.md
MBUS_RESP -- requirements
Module: mbus_resp

Interface
REQ-001 SHALL have parameter RAM_AW, default 11, meaning work-RAM address width (2^RAM_AW bytes).
REQ-002 SHALL have parameter WDOG_FRAMES, default 8, meaning vb rising edges allowed without a watchdog kick.
REQ-003 SHALL have port clk_sys, input, 1, the single system clock.
REQ-004 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have ports cpu_ab, input, 16, and cpu_dout, input, 8: CPU address and write data.
REQ-006 SHALL have ports cpu_rd, cpu_wr, cpu_io and cpu_m1, each input, 1, active-high CPU strobes.
REQ-007 SHALL have port cpu_din, output, 8, read data returned to the CPU.
REQ-008 SHALL have port vb, input, 1, vertical blank.
REQ-009 SHALL have ports rom_addr, output, 15, and rom_data, input, 8, the external program ROM with 1-cycle read latency.
REQ-010 SHALL have ports vram_addr, output, 11; vram_we, output, 1; vram_wdata, output, 8; and vram_rdata, input, 8.
REQ-011 SHALL have ports p1, p2 and dsw, each input, 8: player inputs and DIP switches.
REQ-012 SHALL have ports flip, output, 1; nmi_en, output, 1; snd_cmd, output, 8; snd_stb, output, 1; and wdog_rst, output, 1.

Function
REQ-013 SHALL decode memory cycles (cpu_io=0) as: 0000-7FFF ROM, 8000-87FF work RAM (mirrored on RAM_AW), 9000-97FF VRAM; all else unmapped.
REQ-014 SHALL decode IO cycles (cpu_io=1, cpu_m1=0) on cpu_ab[7:0]: read 00=p1, 01=p2, 02=dsw; write 00 bit0=flip, bit1=nmi_en; write 01=snd_cmd; write 03=watchdog kick.
REQ-015 SHALL treat cpu_io=1 with cpu_m1=1 (interrupt acknowledge) as neither read nor write and return 8'hFF.
REQ-016 SHALL drive rom_addr=cpu_ab[14:0] and vram_addr=cpu_ab[10:0] combinationally.
REQ-017 SHALL run a read FSM: IDLE -> ADDR on the rising edge of cpu_rd -> DATA next cycle -> HOLD next cycle -> IDLE when cpu_rd=0.
REQ-018 SHALL load cpu_din on the ADDR->DATA edge, 2 clk_sys after cpu_rd rises, and hold it until the next read cycle.
REQ-019 SHALL return 8'hFF for unmapped reads and discard unmapped writes.
REQ-020 SHALL accept exactly one write per rising edge of cpu_wr, however long cpu_wr stays high.
REQ-021 SHALL assert vram_we for exactly 1 cycle per VRAM write, with vram_wdata=cpu_dout.
REQ-022 SHALL write work RAM on the same qualified edge, with a synchronous read.
REQ-023 SHALL load snd_cmd on a port-01 write and pulse snd_stb high for 1 cycle after it.
REQ-024 SHALL ignore a cpu_wr edge while cpu_rd=1 and abort the read FSM to IDLE when reset_n asserts mid-cycle.

Reset
REQ-025 SHALL force, while reset_n=0: cpu_din=8'hFF; flip, nmi_en, snd_stb, vram_we and wdog_rst=0; snd_cmd=8'h00; read FSM to IDLE; watchdog count to 0.
REQ-026 SHALL NOT clear work-RAM contents on reset.

Configuration
REQ-027 SHALL, when macro MBUS_WDOG_EN is defined, count vb rising edges, clear the count on a port-03 write, and pulse wdog_rst for 1 cycle and clear the count when it reaches WDOG_FRAMES.
REQ-028 SHALL give a port-03 write priority over a vb edge in the same cycle.
REQ-029 SHALL, without MBUS_WDOG_EN, tie wdog_rst to 0, contain no counter, and ignore port 03.

Verification
REQ-030 SHALL verify that a memory write to 8123 of 5A with cpu_wr held for 17 cycles, then a read of 8123, gives cpu_din=5A 2 cycles after cpu_rd rises and exactly one RAM write.
REQ-031 SHALL verify that an IO read of port 02 with dsw=A5 gives cpu_din=A5, and that an IO cycle with cpu_m1=1 gives cpu_din=FF.
REQ-032 SHALL verify that an IO write to port 01 of 3C gives snd_cmd=3C and one snd_stb pulse, and that port 00 of 03 gives flip=1 and nmi_en=1.
REQ-033 SHALL verify that a read of C000 returns FF and a write to C000 changes no output.
REQ-034 SHALL verify, with MBUS_WDOG_EN defined, that 8 vb edges without a kick give one wdog_rst pulse, and 7 edges followed by a kick give none.
REQ-035 SHALL verify that reset_n asserted during the read FSM DATA state gives cpu_din=FF, the FSM in IDLE, and snd_cmd=00.
